btn_debounce: RTL and testbench
===============================

# btn_debounce

Debounced push-button input conditioner for the board's active-low user buttons. It is the input-side counterpart to the LED-driving blocks. It synchronises the raw button pin, filters contact bounce with a counter-based state machine, and emits a clean level plus single-cycle press, release and long-press event pulses and a wrapping press counter. It sits directly behind a top-level button pin and feeds application logic that needs reliable events.

## Interface
- DEBOUNCE_CYCLES, 250_000: cycles the input must stay stable to accept a change (10 ms at 25 MHz); must be ≥ 2.
- LONG_CYCLES, 25_000_000: cycles in HELD before long_o fires (1 s at 25 MHz); must be ≥ 1.
- ACTIVE_LOW, 1: 1 means btn_i = 0 is pressed; 0 means btn_i = 1 is pressed.
- clk_i  input  1  single system clock; all logic on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- btn_i  input  1  raw asynchronous button pin.
- level_o  output  1  debounced pressed level (1 = pressed).
- press_o  output  1  one-cycle pulse on an accepted press.
- release_o  output  1  one-cycle pulse on an accepted release.
- long_o  output  1  one-cycle pulse, at most once per press, after LONG_CYCLES in HELD.
- count_o  output  8  number of accepted presses, modulo 256.

## Operation
- Synchroniser: two flops on btn_i; reset loads the released level (ACTIVE_LOW ? 1 : 0). pressed_s = second flop, polarity-corrected.
- Counters: deb_cnt is $clog2(DEBOUNCE_CYCLES) bits; hold_cnt is $clog2(LONG_CYCLES) bits and saturates at LONG_CYCLES-1. There is also a long_done flag.
- States and transitions:
  - IDLE: if pressed_s, go to PRESS_WAIT with deb_cnt = 0.
  - PRESS_WAIT:
    - If !pressed_s, return to IDLE (bounce rejected, no output change).
    - Else if deb_cnt == DEBOUNCE_CYCLES-1, go to HELD: press_o = 1, level_o = 1, count_o += 1, hold_cnt = 0, long_done = 0.
    - Else deb_cnt += 1.
  - HELD:
    - If !pressed_s, go to RELEASE_WAIT with deb_cnt = 0.
    - Else if !long_done and hold_cnt == LONG_CYCLES-1: long_o = 1, long_done = 1.
    - Else hold_cnt += 1 (saturating).
  - RELEASE_WAIT:
    - If pressed_s, return to HELD (bounce rejected). hold_cnt and long_done are kept; no press_o is issued.
    - Else if deb_cnt == DEBOUNCE_CYCLES-1, go to IDLE: release_o = 1, level_o = 0.
    - Else deb_cnt += 1. hold_cnt is frozen in this state.
- All outputs are registered. The pulses are high for exactly one cycle. level_o stays 1 throughout HELD and RELEASE_WAIT.
- count_o wraps from 255 to 0 with no flag.
- Reset applies at any time, including mid-press: the state returns to IDLE, every output goes to 0 and the counters clear, with no release_o. If the button is still held after reset, a fresh debounce runs and then issues press_o.

## Timing
- Reset values: level_o = 0, press_o = 0, release_o = 0, long_o = 0, count_o = 0; state IDLE; synchroniser at the released level.
- Press latency: let edge 0 be the first edge that samples a stable pressed level into flop 1. The FSM enters PRESS_WAIT at edge 2. press_o and level_o are high after edge DEBOUNCE_CYCLES+2, and press_o drops after the next edge.
- Release latency is symmetric: release_o is high and level_o is low after edge DEBOUNCE_CYCLES+2, counted from the first edge that samples the released level.
- Long press: with an uninterrupted hold, long_o is high exactly LONG_CYCLES cycles after press_o.
- Press and long cannot coincide. long_o and release_o cannot coincide, because the release path passes through RELEASE_WAIT.
- Any bounce shorter than DEBOUNCE_CYCLES+1 cycles produces no output activity.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20, ACTIVE_LOW = 1.
- Reset: rst_i high for 3 cycles with btn_i = 1 -> all outputs 0, count_o = 0; they stay 0 for 50 idle cycles.
- Clean press: btn_i goes 0 before edge 0 and is held -> press_o high only after edge 6, level_o = 1 from edge 6, count_o = 1.
- Press bounce: btn_i = 0 for 3 cycles, then 1, repeated 5 times, then held 1 -> press_o never asserts, level_o = 0, count_o = 0.
- Long and release: hold 0 for 40 cycles, then 1 -> exactly one press_o, one long_o 20 cycles after press_o, and one release_o 6 edges after the release is sampled. level_o = 0 afterwards.
- Release bounce: while HELD, btn_i = 1 for 2 cycles, then 0 -> no release_o, no second press_o, count_o unchanged. A later long_o still fires once, with the timing shifted by the frozen cycles.
- Wrap and reset mid-hold: 256 clean presses -> count_o = 0. Then press, and assert rst_i while HELD -> outputs are 0 the next cycle with no release_o. With btn_i still 0, press_o re-fires 7 edges after rst_i drops and count_o = 1.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM,
// registered level plus press/release/long pulses and a press counter.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
  parameter int unsigned LONG_CYCLES     = 25_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic [7:0] count_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic          REL_LVL   = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          pressed_s;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ldone_q, ldone_d;
  logic          level_d, press_d, release_d, long_d;
  logic [7:0]    count_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = sync2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      deb_q     <= '0;
      hold_q    <= '0;
      ldone_q   <= 1'b0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      count_o   <= '0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      ldone_q   <= ldone_d;
      level_o   <= level_d;
      press_o   <= press_d;
      release_o <= release_d;
      long_o    <= long_d;
      count_o   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    ldone_d   = ldone_q;
    level_d   = level_o;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    count_d   = count_o;
    unique case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          deb_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          count_d = count_o + 8'd1;
          hold_d  = '0;
          ldone_d = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          deb_d   = '0;
        end else if (!ldone_q && hold_q == HOLD_LAST) begin
          long_d  = 1'b1;
          ldone_d = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      RELEASE_WAIT: begin
        // hold_cnt is frozen here so a rejected release resumes timing
        if (pressed_s) begin
          state_d = HELD;
        end else if (deb_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length reference model, directed
// test-plan scenarios and randomized bounce stimulus.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b1;
  logic       level_o, press_o, release_o, long_o;
  logic [7:0] count_o;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_i    (btn),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o),
    .count_o  (count_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit m_s1 = 1, m_s2 = 1;
  bit m_acc, m_prev, m_ld;
  bit e_press, e_rel, e_long;
  int m_run, m_cnt, m_h;

  // per-scenario observations
  int cyc_bad, ecnt;
  int n_press, n_rel, n_long;
  int press_at, rel_at, long_at;

  // Accepts a level change once the synchronised pin has disagreed
  // with the accepted level for D+1 consecutive samples.
  task automatic model_update(input bit b, input bit r);
    bit ps;
    e_press = 0;
    e_rel   = 0;
    e_long  = 0;
    if (r) begin
      m_s1 = 1; m_s2 = 1;
      m_acc = 0; m_run = 0; m_cnt = 0;
      m_h = 0; m_ld = 0; m_prev = 0;
      return;
    end
    ps = !m_s2;
    if (ps != m_acc) begin
      m_run++;
      if (m_run == D + 1) begin
        m_acc = ps;
        m_run = 0;
        if (ps) begin
          e_press = 1;
          m_cnt = (m_cnt + 1) % 256;
          m_h = 0;
          m_ld = 0;
        end else begin
          e_rel = 1;
        end
      end
    end else begin
      m_run = 0;
      if (m_acc && ps && m_prev) begin
        m_h++;
        if (m_h == L && !m_ld) begin
          e_long = 1;
          m_ld = 1;
        end
      end
    end
    m_prev = ps;
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic clr_obs();
    cyc_bad  = 0;
    ecnt     = -1;
    n_press  = 0; n_rel = 0; n_long = 0;
    press_at = -1; rel_at = -1; long_at = -1;
  endtask

  task automatic step(input bit b, input bit r);
    logic [11:0] exp_v, got_v;
    btn = b;
    rst = r;
    @(posedge clk);
    ecnt++;
    model_update(b, r);
    #1;
    exp_v = {m_acc, e_press, e_rel, e_long, 8'(m_cnt)};
    got_v = {level_o, press_o, release_o, long_o, count_o};
    if (got_v !== exp_v) cyc_bad++;
    if (press_o)   begin n_press++; press_at = ecnt; end
    if (release_o) begin n_rel++;   rel_at   = ecnt; end
    if (long_o)    begin n_long++;  long_at  = ecnt; end
  endtask

  task automatic do_reset();
    repeat (3) step(1, 1);
    repeat (5) step(1, 0);
  endtask

  task automatic test_reset();
    clr_obs();
    repeat (3) step(1, 1);
    n_tests++;
    if ({level_o, press_o, release_o, long_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=0000",
        {level_o, press_o, release_o, long_o});
    end
    n_tests++;
    if (count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d want=0", count_o);
    end
    clr_obs();
    repeat (50) step(1, 0);
    n_tests++;
    if (n_press + n_rel + n_long != 0 || level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle events=%0d level=%b want 0/0",
        n_press + n_rel + n_long, level_o);
    end
    n_tests++;
    if (cyc_bad != 0) begin
      n_fail++;
      $display("FAIL reset_model bad_cycles=%0d want=0", cyc_bad);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    clr_obs();
    repeat (10) step(0, 0);
    n_tests++;
    if (n_press != 1 || press_at != 6) begin
      n_fail++;
      $display("FAIL clean_press_edge got n=%0d at=%0d want n=1 at=6",
        n_press, press_at);
    end
    n_tests++;
    if (level_o !== 1'b1 || count_o !== 8'd1) begin
      n_fail++;
      $display("FAIL clean_press_state level=%b count=%0d want 1/1",
        level_o, count_o);
    end
    n_tests++;
    if (cyc_bad != 0) begin
      n_fail++;
      $display("FAIL clean_press_model bad_cycles=%0d want=0", cyc_bad);
    end
    repeat (10) step(1, 0);
  endtask

  task automatic test_press_bounce();
    do_reset();
    clr_obs();
    repeat (5) begin
      repeat (3) step(0, 0);
      repeat (3) step(1, 0);
    end
    repeat (20) step(1, 0);
    n_tests++;
    if (n_press != 0 || level_o !== 1'b0 || count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL press_bounce n=%0d level=%b count=%0d want 0/0/0",
        n_press, level_o, count_o);
    end
    n_tests++;
    if (cyc_bad != 0) begin
      n_fail++;
      $display("FAIL press_bounce_model bad_cycles=%0d want=0", cyc_bad);
    end
  endtask

  task automatic test_long_release();
    do_reset();
    clr_obs();
    repeat (40) step(0, 0);
    repeat (15) step(1, 0);
    n_tests++;
    if (n_press != 1 || press_at != 6) begin
      n_fail++;
      $display("FAIL long_press got n=%0d at=%0d want n=1 at=6",
        n_press, press_at);
    end
    n_tests++;
    if (n_long != 1 || long_at != 6 + L) begin
      n_fail++;
      $display("FAIL long_pulse got n=%0d at=%0d want n=1 at=%0d",
        n_long, long_at, 6 + L);
    end
    n_tests++;
    if (n_rel != 1 || rel_at != 46 || level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL long_release n=%0d at=%0d level=%b want 1/46/0",
        n_rel, rel_at, level_o);
    end
    n_tests++;
    if (cyc_bad != 0) begin
      n_fail++;
      $display("FAIL long_model bad_cycles=%0d want=0", cyc_bad);
    end
  endtask

  task automatic test_release_bounce();
    do_reset();
    clr_obs();
    repeat (10) step(0, 0);
    repeat (2)  step(1, 0);
    repeat (40) step(0, 0);
    n_tests++;
    if (n_rel != 0 || n_press != 1 || count_o !== 8'd1) begin
      n_fail++;
      $display("FAIL rel_bounce rel=%0d press=%0d count=%0d want 0/1/1",
        n_rel, n_press, count_o);
    end
    // 3 frozen edges push the long pulse from edge 26 to 29
    n_tests++;
    if (n_long != 1 || long_at != 29) begin
      n_fail++;
      $display("FAIL rel_bounce_long got n=%0d at=%0d want n=1 at=29",
        n_long, long_at);
    end
    n_tests++;
    if (cyc_bad != 0) begin
      n_fail++;
      $display("FAIL rel_bounce_model bad_cycles=%0d want=0", cyc_bad);
    end
    repeat (15) step(1, 0);
  endtask

  task automatic test_wrap_reset();
    do_reset();
    clr_obs();
    repeat (256) begin
      repeat (8) step(0, 0);
      repeat (8) step(1, 0);
    end
    n_tests++;
    if (count_o !== 8'd0 || n_press != 256 || n_rel != 256) begin
      n_fail++;
      $display("FAIL wrap count=%0d press=%0d rel=%0d want 0/256/256",
        count_o, n_press, n_rel);
    end
    clr_obs();
    repeat (10) step(0, 0);
    step(0, 1);
    n_tests++;
    if ({level_o, press_o, release_o, long_o} !== 4'b0
        || count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL midhold_reset flags=%b count=%0d want 0000/0",
        {level_o, press_o, release_o, long_o}, count_o);
    end
    ecnt = 0;
    repeat (12) step(0, 0);
    n_tests++;
    if (press_at != 7 || count_o !== 8'd1 || n_rel != 0) begin
      n_fail++;
      $display("FAIL refire at=%0d count=%0d rel=%0d want 7/1/0",
        press_at, count_o, n_rel);
    end
    n_tests++;
    if (cyc_bad != 0) begin
      n_fail++;
      $display("FAIL wrap_model bad_cycles=%0d want=0", cyc_bad);
    end
    repeat (10) step(1, 0);
  endtask

  task automatic test_random();
    int len;
    bit lvl;
    do_reset();
    clr_obs();
    repeat (150) begin
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) len = $urandom_range(25, 45);
      else len = $urandom_range(1, 8);
      if ($urandom_range(0, 40) == 0) step(lvl, 1);
      repeat (len) step(lvl, 0);
    end
    repeat (20) step(1, 0);
    n_tests++;
    if (cyc_bad != 0) begin
      n_fail++;
      $display("FAIL random_model bad_cycles=%0d want=0", cyc_bad);
    end
    n_tests++;
    if (level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL random_final_level got=%b want=0", level_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_long_release();
    test_release_bounce();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
